// File: rtl/niu32_io_ctrl.sv
// niu32_io_ctrl: memory-mapped board I/O for the niu32 core (HEX digits, LEDs, keys, switches).
// Raw keys/switches are synchronized and debounced; key presses latch into a clear-on-write edge register.

module niu32_io_debounce #(
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic db,
    output logic db_next
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;

    // Counter only runs while input and debounced value disagree; any agreement restarts it.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (din != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d = din;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            db_q  <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db      = db_q;
    assign db_next = db_d;
endmodule

module niu32_io_ctrl #(
    parameter int                   WORD_SIZE       = 32,
    parameter int                   DEBOUNCE_CYCLES = 16,
    parameter logic [WORD_SIZE-1:0] ADDR_HEX        = 32'hFFFF0000,
    parameter logic [WORD_SIZE-1:0] ADDR_LEDR       = 32'hFFFF0020,
    parameter logic [WORD_SIZE-1:0] ADDR_LEDG       = 32'hFFFF0040,
    parameter logic [WORD_SIZE-1:0] ADDR_KEY        = 32'hFFFF0100,
    parameter logic [WORD_SIZE-1:0] ADDR_KEYEDGE    = 32'hFFFF0104,
    parameter logic [WORD_SIZE-1:0] ADDR_SWITCH     = 32'hFFFF0120
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] addr,
    input  logic [WORD_SIZE-1:0] wdata,
    input  logic                 we,
    input  logic                 re,
    output logic                 hit,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 rvalid,
    input  logic [3:0]           KEY,
    input  logic [9:0]           SWITCH,
    output logic [9:0]           LEDR,
    output logic [7:0]           LEDG,
    output logic [15:0]          hex_val
);
    localparam int               NBITS    = 14;
    // Keys are active-low, so their idle (released) level is 1.
    localparam logic [NBITS-1:0] SYNC_RST = {10'b0, 4'hF};

    logic [NBITS-1:0]     sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NBITS-1:0]     db, db_next;
    logic [15:0]          hex_q, hex_d;
    logic [9:0]           ledr_q, ledr_d;
    logic [7:0]           ledg_q, ledg_d;
    logic [3:0]           kedge_q, kedge_d;
    logic [WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic [3:0]           pressed, press_set, kedge_clr;
    logic [9:0]           sw_db;
    logic                 sel_hex, sel_ledr, sel_ledg, sel_key, sel_kedge, sel_sw;
    logic                 rd;

    for (genvar i = 0; i < NBITS; i++) begin : g_db
        niu32_io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RST_VAL        (SYNC_RST[i])
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .din    (sync2_q[i]),
            .db     (db[i]),
            .db_next(db_next[i])
        );
    end

    always_comb begin
        sel_hex   = (addr == ADDR_HEX);
        sel_ledr  = (addr == ADDR_LEDR);
        sel_ledg  = (addr == ADDR_LEDG);
        sel_key   = (addr == ADDR_KEY);
        sel_kedge = (addr == ADDR_KEYEDGE);
        sel_sw    = (addr == ADDR_SWITCH);
        hit       = sel_hex | sel_ledr | sel_ledg | sel_key | sel_kedge | sel_sw;
        rd        = re & ~we & hit;

        sync1_d   = {SWITCH, KEY};
        sync2_d   = sync1_q;
        pressed   = ~db[3:0];
        sw_db     = db[13:4];
        // A press is the debounced key falling on this edge, so edge sets in step with pressed.
        press_set = db[3:0] & ~db_next[3:0];
        kedge_clr = (we & sel_kedge) ? wdata[3:0] : 4'h0;
        kedge_d   = (kedge_q & ~kedge_clr) | press_set;

        hex_d  = hex_q;
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        if (we & sel_hex)  hex_d  = wdata[15:0];
        if (we & sel_ledr) ledr_d = wdata[9:0];
        if (we & sel_ledg) ledg_d = wdata[7:0];

        rdata_d  = '0;
        rvalid_d = rd;
        if (rd) begin
            if (sel_hex)   rdata_d = WORD_SIZE'(hex_q);
            if (sel_ledr)  rdata_d = WORD_SIZE'(ledr_q);
            if (sel_ledg)  rdata_d = WORD_SIZE'(ledg_q);
            if (sel_key)   rdata_d = WORD_SIZE'(pressed);
            if (sel_kedge) rdata_d = WORD_SIZE'(kedge_q);
            if (sel_sw)    rdata_d = WORD_SIZE'(sw_db);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= SYNC_RST;
            sync2_q  <= SYNC_RST;
            hex_q    <= '0;
            ledr_q   <= '0;
            ledg_q   <= '0;
            kedge_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            hex_q    <= hex_d;
            ledr_q   <= ledr_d;
            ledg_q   <= ledg_d;
            kedge_q  <= kedge_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign LEDR    = ledr_q;
    assign LEDG    = ledg_q;
    assign hex_val = hex_q;

    logic unused_bits;
    assign unused_bits = ^{wdata[WORD_SIZE-1:16], db_next[13:4]};
endmodule

// File: tb/tb_niu32_io_ctrl.sv
// Bench for niu32_io_ctrl: vector table, directed debounce/edge/reset sequences, then random
// traffic against a sliding-window reference model.

module tb_niu32_io_ctrl;
    localparam logic [31:0] A_HEX     = 32'hFFFF0000;
    localparam logic [31:0] A_LEDR    = 32'hFFFF0020;
    localparam logic [31:0] A_LEDG    = 32'hFFFF0040;
    localparam logic [31:0] A_KEY     = 32'hFFFF0100;
    localparam logic [31:0] A_KEYEDGE = 32'hFFFF0104;
    localparam logic [31:0] A_SWITCH  = 32'hFFFF0120;
    localparam logic [31:0] A_UNMAP   = 32'hFFFF0060;
    localparam logic [13:0] RAW_IDLE  = {10'b0, 4'hF};
    localparam int          DBC       = 16;
    localparam int          NV        = 18;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, rdata;
    logic        we, re, hit, rvalid;
    logic [3:0]  KEY;
    logic [9:0]  SWITCH, LEDR;
    logic [7:0]  LEDG;
    logic [15:0] hex_val;
    logic        last_hit;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    niu32_io_ctrl #(.WORD_SIZE(32), .DEBOUNCE_CYCLES(DBC)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
        .hit(hit), .rdata(rdata), .rvalid(rvalid), .KEY(KEY), .SWITCH(SWITCH),
        .LEDR(LEDR), .LEDG(LEDG), .hex_val(hex_val)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic        exp_hit;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic [15:0] exp_hex;
        logic [9:0]  exp_ledr;
        logic [7:0]  exp_ledg;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(input logic [31:0] a, input logic [31:0] d, input logic w,
                                input logic r, input logic h, input logic rv,
                                input logic [31:0] rdv, input logic [15:0] hx,
                                input logic [9:0] lr, input logic [7:0] lg);
        vec_t v;
        v.addr = a; v.wdata = d; v.we = w; v.re = r; v.exp_hit = h; v.exp_rvalid = rv;
        v.exp_rdata = rdv; v.exp_hex = hx; v.exp_ledr = lr; v.exp_ledg = lg;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; hit is sampled before the next edge.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        addr = a; wdata = d; we = w; re = r;
        #1 last_hit = hit;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Reference model: a bit flips once the 16 synchronized samples feeding the current edge
    // all disagree with it; synchronized sample at edge n is the raw value applied at edge n-2.
    logic [13:0] hist[$];
    logic [13:0] m_db;
    logic [15:0] m_hex;
    logic [9:0]  m_ledr;
    logic [7:0]  m_ledg;
    logic [3:0]  m_edge;
    logic        e_rvalid;
    logic [31:0] e_rdata;

    function automatic logic model_hit(input logic [31:0] a);
        return a == A_HEX || a == A_LEDR || a == A_LEDG || a == A_KEY ||
               a == A_KEYEDGE || a == A_SWITCH;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DBC + 2; i++) hist.push_back(RAW_IDLE);
        m_db = RAW_IDLE; m_hex = '0; m_ledr = '0; m_ledg = '0; m_edge = '0;
        e_rvalid = 1'b0; e_rdata = '0;
    endtask

    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic w,
                              input logic r, input logic rst, input logic [13:0] raw);
        logic [13:0] ndb;
        logic [3:0]  set;
        logic        stable;
        if (rst) begin
            model_reset();
            return;
        end
        e_rvalid = r && !w && model_hit(a);
        e_rdata  = '0;
        if (e_rvalid) begin
            if (a == A_HEX)     e_rdata = {16'b0, m_hex};
            if (a == A_LEDR)    e_rdata = {22'b0, m_ledr};
            if (a == A_LEDG)    e_rdata = {24'b0, m_ledg};
            if (a == A_KEY)     e_rdata = {28'b0, ~m_db[3:0]};
            if (a == A_KEYEDGE) e_rdata = {28'b0, m_edge};
            if (a == A_SWITCH)  e_rdata = {22'b0, m_db[13:4]};
        end
        hist.push_front(raw);
        void'(hist.pop_back());
        ndb = m_db;
        for (int b = 0; b < 14; b++) begin
            stable = 1'b1;
            for (int k = 2; k < DBC + 2; k++) if (hist[k][b] == m_db[b]) stable = 1'b0;
            if (stable) ndb[b] = ~m_db[b];
        end
        set = m_db[3:0] & ~ndb[3:0];
        if (w && a == A_KEYEDGE) m_edge = m_edge & ~d[3:0];
        m_edge = m_edge | set;
        if (w && a == A_HEX)  m_hex  = d[15:0];
        if (w && a == A_LEDR) m_ledr = d[9:0];
        if (w && a == A_LEDG) m_ledg = d[7:0];
        m_db = ndb;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] amap[6];
        logic [31:0] a, d;
        logic        w, r, rst, eh;
        logic [13:0] raw;
        int          hold, sel;

        amap[0] = A_HEX; amap[1] = A_LEDR; amap[2] = A_LEDG;
        amap[3] = A_KEY; amap[4] = A_KEYEDGE; amap[5] = A_SWITCH;

        vecs[0]  = mk(A_HEX,      32'h0000BEEF, 1, 0, 1, 0, 32'h0,      16'hBEEF, 10'h0,   8'h0);
        vecs[1]  = mk(A_HEX,      32'h0,        0, 1, 1, 1, 32'hBEEF,   16'hBEEF, 10'h0,   8'h0);
        vecs[2]  = mk(A_LEDR,     32'hFFFFFFFF, 1, 0, 1, 0, 32'h0,      16'hBEEF, 10'h3FF, 8'h0);
        vecs[3]  = mk(A_LEDR,     32'h0,        0, 1, 1, 1, 32'h3FF,    16'hBEEF, 10'h3FF, 8'h0);
        vecs[4]  = mk(A_LEDG,     32'h12345678, 1, 0, 1, 0, 32'h0,      16'hBEEF, 10'h3FF, 8'h78);
        vecs[5]  = mk(A_LEDG,     32'h0,        0, 1, 1, 1, 32'h78,     16'hBEEF, 10'h3FF, 8'h78);
        vecs[6]  = mk(A_HEX,      32'hCAFE1234, 1, 1, 1, 0, 32'h0,      16'h1234, 10'h3FF, 8'h78);
        vecs[7]  = mk(A_UNMAP,    32'hAAAA5555, 1, 0, 0, 0, 32'h0,      16'h1234, 10'h3FF, 8'h78);
        vecs[8]  = mk(A_SWITCH,   32'hFFFFFFFF, 1, 0, 1, 0, 32'h0,      16'h1234, 10'h3FF, 8'h78);
        vecs[9]  = mk(A_UNMAP,    32'h0,        0, 1, 0, 0, 32'h0,      16'h1234, 10'h3FF, 8'h78);
        vecs[10] = mk(A_SWITCH,   32'h0,        0, 1, 1, 1, 32'h0,      16'h1234, 10'h3FF, 8'h78);
        vecs[11] = mk(A_KEY,      32'h0,        0, 1, 1, 1, 32'h0,      16'h1234, 10'h3FF, 8'h78);
        vecs[12] = mk(A_KEY,      32'hF,        1, 0, 1, 0, 32'h0,      16'h1234, 10'h3FF, 8'h78);
        vecs[13] = mk(A_KEYEDGE,  32'h0,        0, 1, 1, 1, 32'h0,      16'h1234, 10'h3FF, 8'h78);
        vecs[14] = mk(32'hFFFF0001, 32'h0,      0, 1, 0, 0, 32'h0,      16'h1234, 10'h3FF, 8'h78);
        vecs[15] = mk(32'h7FFF0000, 32'h0,      0, 1, 0, 0, 32'h0,      16'h1234, 10'h3FF, 8'h78);
        vecs[16] = mk(A_HEX,      32'h0,        0, 1, 1, 1, 32'h1234,   16'h1234, 10'h3FF, 8'h78);
        vecs[17] = mk(A_LEDG,     32'h0,        0, 0, 1, 0, 32'h0,      16'h1234, 10'h3FF, 8'h78);

        // Reset, with a write in flight that must be dropped
        reset = 1'b1; KEY = 4'hF; SWITCH = '0;
        addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
        #1;
        step(32'h0, 32'h0, 0, 0);
        step(A_HEX, 32'hFFFF, 1, 1);
        reset = 1'b0;
        chk("reset LEDR", LEDR, 0);
        chk("reset LEDG", LEDG, 0);
        chk("reset hex_val", hex_val, 0);
        chk("reset rvalid", rvalid, 0);
        chk("reset rdata", rdata, 0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].re);
            chk($sformatf("vec%0d hit", i),    last_hit, vecs[i].exp_hit);
            chk($sformatf("vec%0d rvalid", i), rvalid,   vecs[i].exp_rvalid);
            chk($sformatf("vec%0d rdata", i),  rdata,    vecs[i].exp_rdata);
            chk($sformatf("vec%0d hex", i),    hex_val,  vecs[i].exp_hex);
            chk($sformatf("vec%0d ledr", i),   LEDR,     vecs[i].exp_ledr);
            chk($sformatf("vec%0d ledg", i),   LEDG,     vecs[i].exp_ledg);
        end

        // KEY[2] press: pressed visible after edge 18, so a read on edge 19 first reports it
        KEY = 4'b1011;
        for (int n = 1; n <= 25; n++) begin
            step(A_KEY, 32'h0, 0, 1);
            chk($sformatf("key2 latency n=%0d", n), rdata, (n >= 19) ? 32'h4 : 32'h0);
        end
        step(A_KEYEDGE, 32'h0, 0, 1);
        chk("keyedge after press", rdata, 32'h4);
        step(A_KEYEDGE, 32'h0, 0, 1);
        chk("keyedge read does not clear", rdata, 32'h4);
        step(A_KEYEDGE, 32'h4, 1, 0);
        step(A_KEYEDGE, 32'h0, 0, 1);
        chk("keyedge cleared", rdata, 32'h0);
        KEY = 4'hF;
        idle(20);
        step(A_KEYEDGE, 32'h0, 0, 1);
        chk("release sets no edge", rdata, 32'h0);

        // Switch glitch of 10 cycles never reaches the debounced value
        for (int n = 0; n < 40; n++) begin
            SWITCH = (n < 10) ? 10'h020 : 10'h000;
            step(A_SWITCH, 32'h0, 0, 1);
            chk($sformatf("sw glitch n=%0d", n), rdata, 32'h0);
        end
        SWITCH = 10'h3FF;
        idle(17);
        step(A_SWITCH, 32'h0, 0, 1);
        chk("sw before latency", rdata, 32'h0);
        step(A_SWITCH, 32'h0, 0, 1);
        chk("sw after latency", rdata, 32'h3FF);
        SWITCH = 10'h0;
        idle(20);

        // Edge set and clear on the same edge: set wins
        KEY = 4'b1110;
        idle(17);
        step(A_KEYEDGE, 32'h1, 1, 0);
        step(A_KEYEDGE, 32'h0, 0, 1);
        chk("edge set beats clear", rdata, 32'h1);
        step(A_KEYEDGE, 32'h1, 1, 0);
        step(A_KEYEDGE, 32'h0, 0, 1);
        chk("edge clear later", rdata, 32'h0);
        KEY = 4'hF;
        idle(20);

        // Reset concurrent with a write
        step(A_LEDR, 32'h3FF, 1, 0);
        chk("ledr before reset", LEDR, 32'h3FF);
        reset = 1'b1;
        step(A_LEDG, 32'hFF, 1, 0);
        reset = 1'b0;
        chk("post-reset LEDR", LEDR, 0);
        chk("post-reset LEDG", LEDG, 0);
        chk("post-reset rvalid", rvalid, 0);
        step(A_LEDG, 32'h5A, 1, 0);
        chk("first write after reset", LEDG, 32'h5A);
        step(A_LEDG, 32'h0, 0, 1);
        chk("first read after reset rvalid", rvalid, 1);
        chk("first read after reset rdata", rdata, 32'h5A);

        // Random traffic against the reference model
        reset = 1'b1;
        model_step(32'h0, 32'h0, 0, 0, 1, RAW_IDLE);
        step(32'h0, 32'h0, 0, 0);
        reset = 1'b0;
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            if (hold == 0) begin
                raw = 14'($urandom);
                KEY = raw[3:0];
                SWITCH = raw[13:4];
                hold = $urandom_range(1, 40);
            end
            hold--;
            sel = $urandom_range(0, 7);
            if (sel < 6)       a = amap[sel];
            else if (sel == 6) a = amap[$urandom_range(0, 5)] ^ (32'h1 << $urandom_range(0, 31));
            else               a = $urandom;
            d   = $urandom;
            w   = ($urandom_range(0, 3) == 0);
            r   = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 299) == 0);
            reset = rst;
            eh  = model_hit(a);
            model_step(a, d, w, r, rst, {SWITCH, KEY});
            step(a, d, w, r);
            reset = 1'b0;
            chk($sformatf("rnd%0d hit", c),    last_hit, eh);
            chk($sformatf("rnd%0d rvalid", c), rvalid,   e_rvalid);
            chk($sformatf("rnd%0d rdata", c),  rdata,    e_rdata);
            chk($sformatf("rnd%0d hex", c),    hex_val,  m_hex);
            chk($sformatf("rnd%0d ledr", c),   LEDR,     m_ledr);
            chk($sformatf("rnd%0d ledg", c),   LEDG,     m_ledg);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/niu32_io_ctrl.md
NIU32_IO_CTRL -- requirements
Module: niu32_io_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32, the data and address width.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the consecutive stable cycles required before a debounced input changes.
REQ-003 The block SHALL have parameters ADDR_HEX=32'hFFFF0000, ADDR_LEDR=32'hFFFF0020, ADDR_LEDG=32'hFFFF0040, ADDR_KEY=32'hFFFF0100, ADDR_KEYEDGE=32'hFFFF0104, ADDR_SWITCH=32'hFFFF0120.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk  in  1  system clock; reset  in  1  synchronous active-high reset.
REQ-005 Ports SHALL be: addr in 32 CPU address; wdata in 32 store data; we in 1 store strobe; re in 1 load strobe.
REQ-006 Ports SHALL be: hit out 1 addr matches a mapped register (combinational); rdata out 32 load data; rvalid out 1 rdata valid.
REQ-007 Ports SHALL be: KEY in 4 raw pushbuttons, active-low, asynchronous; SWITCH in 10 raw switches, asynchronous.
REQ-008 Ports SHALL be: LEDR out 10 red LEDs; LEDG out 8 green LEDs; hex_val out 16 value for four seven-segment digits, nibble 0 = HEX0.

Function
REQ-009 KEY and SWITCH SHALL each pass through a two-flop synchronizer before any other use.
REQ-010 Each of the 14 synchronized bits SHALL have its own debounce counter: reset to 0 whenever the synchronized bit equals the debounced bit, else increment; when the count reaches DEBOUNCE_CYCLES-1 while still differing, the debounced bit SHALL take the synchronized value on that edge and the counter SHALL clear.
REQ-011 Total latency from a clean raw input change to the debounced change SHALL be exactly DEBOUNCE_CYCLES+2 cycles; any glitch shorter than DEBOUNCE_CYCLES cycles SHALL never change the debounced bit.
REQ-012 pressed[3:0] SHALL equal the inverted debounced KEY bits.
REQ-013 The 4-bit edge register SHALL set bit i on the cycle pressed[i] goes 0->1 and SHALL hold until cleared.
REQ-014 A write to ADDR_KEYEDGE SHALL clear edge bits where wdata[3:0] is 1; on simultaneous set and clear of the same bit, set SHALL win.
REQ-015 hit SHALL be 1 only when addr equals one of the six mapped addresses exactly; no partial decode.
REQ-016 A write (we=1, hit=1) SHALL update the target on the next clk edge: ADDR_HEX <- wdata[15:0]; ADDR_LEDR <- wdata[9:0]; ADDR_LEDG <- wdata[7:0]; ADDR_KEY and ADDR_SWITCH are read-only and writes SHALL be ignored.
REQ-017 A read (re=1, we=0, hit=1) SHALL register rdata on the next edge with rvalid=1 for exactly that one cycle; the read value SHALL be zero-extended: HEX {16'b0,hex}, LEDR {22'b0,LEDR}, LEDG {24'b0,LEDG}, KEY {28'b0,pressed}, KEYEDGE {28'b0,edge}, SWITCH {22'b0,debounced SWITCH}.
REQ-018 If we and re are both 1, the write SHALL occur and the cycle SHALL produce no rvalid.
REQ-019 Accesses with hit=0 SHALL change no state; the following cycle SHALL have rvalid=0 and rdata=0.
REQ-020 When rvalid=0, rdata SHALL be 0.
REQ-021 A read of ADDR_KEYEDGE SHALL NOT clear edge bits; only writes clear.
REQ-022 Back-to-back accesses on consecutive cycles SHALL each be serviced; there SHALL be no stall and no busy state.

Reset
REQ-023 On reset: LEDR=0, LEDG=0, hex_val=0, rdata=0, rvalid=0, edge=0, all debounce counters=0, synchronizer flops=1 (keys released), debounced KEY=4'hF, debounced SWITCH=0.
REQ-024 Reset SHALL override any simultaneous we/re and any pending edge set; the cycle after reset is deasserted SHALL accept accesses normally.

Verification
REQ-025 Write 32'h0000BEEF to ADDR_HEX, then read it -> hex_val=16'hBEEF the cycle after the write; read returns rdata=32'h0000BEEF with rvalid=1 for one cycle.
REQ-026 Hold KEY[2]=0 for 20 cycles (DEBOUNCE_CYCLES=16) -> pressed[2] rises exactly 18 cycles after the KEY change; edge reads 32'h4; write 32'h4 to ADDR_KEYEDGE -> edge reads 0.
REQ-027 Pulse SWITCH[5]=1 for 10 cycles then 0 -> SWITCH read stays 32'h0 throughout.
REQ-028 Set edge bit 0 while writing 32'h1 to ADDR_KEYEDGE in the same cycle -> edge[0]=1 afterwards.
REQ-029 Write to 32'hFFFF0060 and to ADDR_SWITCH, then read 32'hFFFF0060 -> hit=0 for the unmapped address, all outputs unchanged, rvalid=0 and rdata=0 on the read.
REQ-030 Write 32'h3FF to ADDR_LEDR, then assert reset for one cycle concurrently with a we to ADDR_LEDG -> LEDR=0, LEDG=0, rvalid=0 after reset.
